// File: rtl/ifetch_ctrl_pkg.sv
// Shared MIPS32 fetch definitions: front-end state encoding and halt opcode.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ifetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [5:0] HALT_OPCODE = 6'h3F;

  function automatic logic is_halt(input logic [31:0] instr);
    return instr[31:26] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: DEPTH entries of {instr, pc}, with a single-cycle flush.
// Latency: a write at edge N is visible at the head after edge N.
// Backpressure: caller writes only when !full or while reading; flush beats wr/rd.
// Ports: flush/wr_en/rd_en controls, wr_instr/wr_pc tail data,
//        vld/full status, head_instr/head_pc head entry.
module ifetch_fifo #(
  parameter int AW    = 10,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [31:0]   wr_instr,
  input  logic [AW-1:0] wr_pc,
  input  logic          rd_en,
  output logic          vld,
  output logic          full,
  output logic [31:0]   head_instr,
  output logic [AW-1:0] head_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] pc_mem    [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          do_wr, do_rd;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign vld        = (count != '0);
  assign full       = (count == CW'(DEPTH));
  assign do_rd      = rd_en && vld;
  // A write into a full buffer is only legal when the head leaves the same edge.
  assign do_wr      = wr_en && (!full || do_rd);
  assign head_instr = instr_mem[head];
  assign head_pc    = pc_mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (flush) begin
      // Stale entries stay in storage; only the pointers and count are cleared.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_wr) begin
        instr_mem[tail] <= wr_instr;
        pc_mem[tail]    <= wr_pc;
        tail            <= ptr_next(tail);
      end
      if (do_rd) begin
        head <= ptr_next(head);
      end
      if (do_wr && !do_rd) begin
        count <= count + CW'(1);
      end else if (do_rd && !do_wr) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: drives a combinational imem and fills a prefetch buffer.
// Latency: start/redirect at edge N -> first fetch at N+1 -> out_valid after N+1.
// Backpressure: out_ready low stalls fetch once the buffer is full; head is held stable.
// Ports: clk/rst; start, redirect_valid/redirect_pc controls; imem_addr/imem_data memory;
//        out_valid/out_ready/out_instr/out_pc decode handshake; halted status.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [AW-1:0] out_pc,
  output logic          halted
);

  state_t        state;
  logic [AW-1:0] pc;
  logic          fifo_full;
  logic          pop;
  logic          redirect_take;
  logic          fetch;

  assign pop           = out_valid && out_ready;
  // Redirects only count once the front end has been started.
  assign redirect_take = redirect_valid && (state != ST_IDLE);
  assign fetch         = (state == ST_RUN) && !redirect_take && (!fifo_full || pop);
  assign imem_addr     = {{(32 - AW){1'b0}}, pc};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      pc     <= '0;
      halted <= 1'b0;
    end else if (redirect_take) begin
      state  <= ST_RUN;
      pc     <= redirect_pc;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            pc    <= '0;
          end
        end
        ST_RUN: begin
          if (fetch) begin
            pc <= pc + AW'(1);
            // The halt word itself is enqueued; fetching stops after it.
            if (is_halt(imem_data)) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  ifetch_fifo #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_take),
    .wr_en      (fetch),
    .wr_instr   (imem_data),
    .wr_pc      (pc),
    .rd_en      (pop),
    .vld        (out_valid),
    .full       (fifo_full),
    .head_instr (out_instr),
    .head_pc    (out_pc)
  );

endmodule

// File: tb/tb_ifetch_ctrl.sv
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [9:0]  out_pc;
  logic        halted;

  logic [31:0] mem [1024];
  logic [31:0] img [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[9:0]];

  ifetch_ctrl #(.AW(10), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // start is sampled at the next posedge (edge N); returns at the negedge after N.
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    checks++; if (out_pc !== 10'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_imem_addr got=%h exp=0", imem_addr); end
    // redirect in IDLE must be ignored
    redirect_pc = 10'h155; redirect_valid = 1'b1;
    @(posedge clk); #1 redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL idle_redirect_ignored got valid=%b addr=%h exp valid=0 addr=0", out_valid, imem_addr);
    end
  endtask

  task automatic test_halt_stream();
    int nb;
    logic [9:0]  bpc [8];
    logic [31:0] bin [8];
    int          bk  [8];
    do_reset();
    out_ready = 1'b1;
    pulse_start();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL start_latency_early got=%b exp=0", out_valid); end
    nb = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid && nb < 8) begin bpc[nb] = out_pc; bin[nb] = out_instr; bk[nb] = k; nb++; end
    end
    checks++; if (nb !== 4) begin failures++; $display("FAIL halt_beat_count got=%0d exp=4", nb); end
    for (int i = 0; i < 4 && i < nb; i++) begin
      checks++; if (bpc[i] !== 10'(i) || bin[i] !== img[i] || bk[i] !== i) begin
        failures++; $display("FAIL halt_beat%0d got pc=%h instr=%h cyc=%0d exp pc=%h instr=%h cyc=%0d",
                             i, bpc[i], bin[i], bk[i], 10'(i), img[i], i);
      end
    end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halted_set got=%b exp=1", halted); end
    checks++; if (imem_addr !== 32'd4) begin failures++; $display("FAIL halted_pc_hold got=%h exp=4", imem_addr); end
  endtask

  task automatic test_backpressure();
    int nb;
    logic [9:0]  bpc [8];
    logic [31:0] bin [8];
    do_reset();
    out_ready = 1'b0;
    pulse_start();
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j == 2) begin
        checks++; if (imem_addr !== 32'd2) begin failures++; $display("FAIL bp_addr_mid got=%h exp=2", imem_addr); end
      end
    end
    checks++; if (out_valid !== 1'b1 || imem_addr !== 32'd2) begin
      failures++; $display("FAIL bp_full got valid=%b addr=%h exp valid=1 addr=2", out_valid, imem_addr);
    end
    checks++; if (out_instr !== 32'h11111111 || out_pc !== 10'h0) begin
      failures++; $display("FAIL bp_head got instr=%h pc=%h exp instr=11111111 pc=0", out_instr, out_pc);
    end
    out_ready = 1'b1;
    nb = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid && nb < 8) begin bpc[nb] = out_pc; bin[nb] = out_instr; nb++; end
      @(negedge clk);
    end
    checks++; if (nb !== 4) begin failures++; $display("FAIL bp_beat_count got=%0d exp=4", nb); end
    for (int i = 0; i < 4 && i < nb; i++) begin
      checks++; if (bpc[i] !== 10'(i) || bin[i] !== img[i]) begin
        failures++; $display("FAIL bp_beat%0d got pc=%h instr=%h exp pc=%h instr=%h", i, bpc[i], bin[i], 10'(i), img[i]);
      end
    end
  endtask

  task automatic test_redirect_pop();
    logic found;
    do_reset();
    out_ready = 1'b1;
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (out_valid && out_pc == 10'd1) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL rd_wait_pc1 got=timeout exp=pc1 beat"); end
    redirect_pc = 10'h200; redirect_valid = 1'b1;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_flushed got=%b exp=0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 10'h200 || out_instr !== mem[10'h200]) begin
      failures++; $display("FAIL rd_first got valid=%b pc=%h instr=%h exp valid=1 pc=200 instr=%h",
                           out_valid, out_pc, out_instr, mem[10'h200]);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 10'h201) begin
      failures++; $display("FAIL rd_second got valid=%b pc=%h exp valid=1 pc=201", out_valid, out_pc);
    end
  endtask

  // Entered from HALTED: the redirect must also restart fetching.
  task automatic test_wrap();
    test_halt_stream();
    redirect_pc = 10'h3FF; redirect_valid = 1'b1;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (halted !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL wrap_redirect got halted=%b valid=%b exp halted=0 valid=0", halted, out_valid);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 10'h3FF || out_instr !== mem[10'h3FF]) begin
      failures++; $display("FAIL wrap_last got valid=%b pc=%h instr=%h exp valid=1 pc=3ff instr=%h",
                           out_valid, out_pc, out_instr, mem[10'h3FF]);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 10'h000 || out_instr !== 32'h11111111) begin
      failures++; $display("FAIL wrap_zero got valid=%b pc=%h instr=%h exp valid=1 pc=0 instr=11111111",
                           out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_reset_mid();
    // Reset while HALTED, with every other input asserted.
    test_halt_stream();
    rst = 1'b1; start = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'h0AA; out_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (halted !== 1'b0 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 10'h0 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL rst_halted got halted=%b valid=%b instr=%h pc=%h addr=%h exp all 0",
                           halted, out_valid, out_instr, out_pc, imem_addr);
    end
    redirect_valid = 1'b1;
    @(posedge clk); #1 redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL rst_redirect_ignored got valid=%b addr=%h exp valid=0 addr=0", out_valid, imem_addr);
    end
    pulse_start();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 10'h0 || out_instr !== 32'h11111111) begin
      failures++; $display("FAIL rst_restart got valid=%b pc=%h instr=%h exp valid=1 pc=0 instr=11111111",
                           out_valid, out_pc, out_instr);
    end
    // Reset while the buffer is full.
    do_reset();
    pulse_start();
    repeat (4) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || imem_addr !== 32'd2) begin
      failures++; $display("FAIL rst_full_pre got valid=%b addr=%h exp valid=1 addr=2", out_valid, imem_addr);
    end
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'h123;
    @(posedge clk); #1 rst = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (halted !== 1'b0 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 10'h0 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL rst_full got halted=%b valid=%b instr=%h pc=%h addr=%h exp all 0",
                           halted, out_valid, out_instr, out_pc, imem_addr);
    end
  endtask

  initial begin
    img[0] = 32'h11111111; img[1] = 32'h22222222; img[2] = 32'h33333333; img[3] = 32'hFC000000;
    for (int i = 0; i < 1024; i++) mem[i] = {6'h01, 26'(i)};
    for (int i = 0; i < 4; i++) mem[i] = img[i];
    rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

    test_reset();
    test_halt_stream();
    test_backpressure();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
